mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//   Consumer end of the EX/MEM pipeline register: takes the registered ALU address, store data and
//   MemRead/MemWrite controls, runs one word access on the data-memory bus with a valid/ready request
//   and a valid response, and stalls the pipeline until the access completes.
//   Load data and a completion/fault indication go to the MEM/WB register; bus timeouts become faults.
// PARAMETERS
//   TIMEOUT_CYCLES  64  cycles allowed in REQ or WAIT without progress before a fault (>=2)
//   CNT_W            7  timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//   clk                  in   1   clock; all state updates on rising edge
//   reset                in   1   synchronous, active-low reset
//   Mem_In_Aluresult     in  32   effective address from EX/MEM
//   Mem_In_ReadData2     in  32   store data from EX/MEM
//   Mem_In_MemRead       in   1   load request from EX/MEM
//   Mem_In_MemWrite      in   1   store request from EX/MEM
//   Mem_Stall            out  1   hold PC/IF/ID/ID-EX/EX-MEM; bubble into MEM/WB (combinational)
//   Mem_Out_LoadData     out 32   registered load data, valid while Mem_Out_Done=1
//   Mem_Out_Done         out  1   one-cycle pulse: access finished (DONE state)
//   Mem_Out_Fault        out  1   with Done: misaligned, illegal (read+write) or timeout
//   dmem_req_valid       out  1   request valid (registered)
//   dmem_req_ready       in   1   memory accepts request when valid&&ready
//   dmem_req_we          out  1   1=store, 0=load (registered)
//   dmem_req_addr        out 32   word address, bits[1:0]=0 (registered)
//   dmem_req_wdata       out 32   store data (registered)
//   dmem_resp_valid      in   1   load response valid; honoured only in WAIT
//   dmem_resp_rdata      in  32   load response data
// BEHAVIOUR
//   Reset (reset==0 at edge): state=IDLE, counter=0; req_valid/we=0, addr/wdata=0; LoadData=0, Done=0, Fault=0.
//   States: IDLE, REQ, WAIT, DONE.
//   IDLE: access = MemRead|MemWrite. No access -> stay, Mem_Stall=0.
//     Legal access (exactly one of Read/Write, addr[1:0]==0): Mem_Stall=1; capture addr/wdata/we; -> REQ.
//     Illegal (both set, or addr[1:0]!=0): Mem_Stall=1; no bus request; Fault<=1, LoadData<=0; -> DONE.
//   REQ: req_valid=1, payload stable until accept. Mem_Stall=1.
//     valid&&ready: store -> DONE (posted, no response); load -> WAIT. req_valid drops next cycle.
//   WAIT: Mem_Stall=1. resp_valid -> LoadData<=resp_rdata, Fault<=0, -> DONE. resp_valid in any other state ignored.
//   Timeout: counter clears on entry to REQ and WAIT, increments each cycle there; at TIMEOUT_CYCLES-1
//     without accept/response -> DONE, Fault=1, LoadData=0; request withdrawn (req_valid=0 next cycle).
//   DONE: Mem_Stall=0, Done=1 for exactly one cycle, LoadData/Fault held; -> IDLE unconditionally.
//     The edge leaving DONE advances EX/MEM, so IDLE never re-issues the same access.
//   Latency (ready and resp each in first possible cycle): load 3 stall cycles, store 2, illegal 1.
//   Back-to-back accesses: each one passes through IDLE; at most one outstanding request.
//   Reset mid-access: IDLE on next edge, request dropped; a late response is ignored.
//   Done/Fault and LoadData change only on the transition into DONE or on reset.
// STRUCTURE
//   Shared package riscv_mem_pkg: state encodings (LSU_IDLE=2'd0, LSU_REQ=2'd1, LSU_WAIT=2'd2, LSU_DONE=2'd3),
//     WORD_ALIGN_MASK=2'b11.
//   Sub-module lsu_timeout_ctr (clear, enable, expired output) parameterised by TIMEOUT_CYCLES/CNT_W.
//   Top: FSM, request payload registers, response capture, combinational Mem_Stall.
// TESTING
//   1 Load addr=0x100, ready=1 in REQ, resp next cycle rdata=0xDEADBEEF -> stall 3 cycles, Done pulse,
//     LoadData=0xDEADBEEF, Fault=0.
//   2 Store addr=0x204 wdata=0x12345678, ready held low 3 cycles -> payload stable while valid,
//     one accept, Done 1 cycle later, stall 5 cycles total.
//   3 Load addr=0x102 -> no req_valid, Done+Fault the next cycle, LoadData=0, stall 1 cycle.
//   4 MemRead=MemWrite=1 -> Fault, no bus request. Load with no response, TIMEOUT_CYCLES=8 ->
//     Fault after 8 WAIT cycles, then IDLE.
//   5 reset=0 during WAIT, then resp_valid pulse -> IDLE, every output at its reset value, response ignored.
//   6 Two loads back to back (0x10, 0x14) -> exactly two accepted requests in order, two Done pulses,
//     correct data for each.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory stage: LSU state encoding and
// word-alignment helpers.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // A word access is legal only when the byte-offset bits are clear.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Progress watchdog for the LSU: counts cycles spent waiting on the bus and
// flags the last allowed cycle so the FSM can give up on the access.
module lsu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Expired is raised during the final permitted cycle, not after it.
  assign expired = enable && (count_reg == LAST_COUNT);

  // Count up while enabled; saturate at the last value so it never wraps.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the EX/MEM MemRead/MemWrite controls into a
// single valid/ready word access on the data bus, stalls the pipeline until
// it completes, and reports load data plus a fault flag to MEM/WB.
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Mem_In_Aluresult,
  input  logic [31:0] Mem_In_ReadData2,
  input  logic        Mem_In_MemRead,
  input  logic        Mem_In_MemWrite,
  output logic        Mem_Stall,
  output logic [31:0] Mem_Out_LoadData,
  output logic        Mem_Out_Done,
  output logic        Mem_Out_Fault,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata
);

  lsu_state_t state_reg;
  lsu_state_t state_next;

  logic access;
  logic legal;
  logic accept;
  logic resp_take;
  logic timed_out;
  logic ctr_enable;
  logic ctr_clear;

  assign access     = Mem_In_MemRead | Mem_In_MemWrite;
  assign legal      = (Mem_In_MemRead ^ Mem_In_MemWrite) && is_word_aligned(Mem_In_Aluresult);
  assign accept     = (state_reg == LSU_REQ) && dmem_req_valid && dmem_req_ready;
  assign resp_take  = (state_reg == LSU_WAIT) && dmem_resp_valid;
  assign ctr_enable = (state_reg == LSU_REQ) || (state_reg == LSU_WAIT);
  // Any progress restarts the watchdog, so WAIT gets its own full budget.
  assign ctr_clear  = !ctr_enable || accept || resp_take;

  // The pipeline is frozen for every cycle of an access except DONE.
  assign Mem_Stall = ((state_reg == LSU_IDLE) && access) ||
                     (state_reg == LSU_REQ) || (state_reg == LSU_WAIT);

  lsu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(timed_out)
  );

  // Next-state selection; acceptance/response take priority over timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: if (access) state_next = legal ? LSU_REQ : LSU_DONE;
      LSU_REQ: begin
        if (accept)         state_next = dmem_req_we ? LSU_DONE : LSU_WAIT;
        else if (timed_out) state_next = LSU_DONE;
      end
      LSU_WAIT: if (resp_take || timed_out) state_next = LSU_DONE;
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  // State, bus request payload and MEM/WB results; results move only when DONE is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= LSU_IDLE;
      dmem_req_valid   <= 1'b0;
      dmem_req_we      <= 1'b0;
      dmem_req_addr    <= '0;
      dmem_req_wdata   <= '0;
      Mem_Out_LoadData <= '0;
      Mem_Out_Done     <= 1'b0;
      Mem_Out_Fault    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      Mem_Out_Done <= (state_next == LSU_DONE);
      case (state_reg)
        LSU_IDLE: begin
          if (access && legal) begin
            dmem_req_valid <= 1'b1;
            dmem_req_we    <= Mem_In_MemWrite;
            dmem_req_addr  <= Mem_In_Aluresult;
            dmem_req_wdata <= Mem_In_ReadData2;
          end else if (access) begin
            Mem_Out_Fault    <= 1'b1;
            Mem_Out_LoadData <= '0;
          end
        end
        LSU_REQ: begin
          if (accept) begin
            dmem_req_valid <= 1'b0;
            if (dmem_req_we) begin
              Mem_Out_Fault    <= 1'b0;
              Mem_Out_LoadData <= '0;
            end
          end else if (timed_out) begin
            dmem_req_valid   <= 1'b0;
            Mem_Out_Fault    <= 1'b1;
            Mem_Out_LoadData <= '0;
          end
        end
        LSU_WAIT: begin
          if (resp_take) begin
            Mem_Out_LoadData <= dmem_resp_rdata;
            Mem_Out_Fault    <= 1'b0;
          end else if (timed_out) begin
            Mem_Out_LoadData <= '0;
            Mem_Out_Fault    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
